// File: rtl/seq_miter_cmp.sv
// Sequential miter: compares a gate-level stream against a gold stream delayed by
// DELAY valid beats, with per-bit care masks, saturating counters and first-failure capture.
module seq_miter_cmp #(
   parameter  int WIDTH    = 8,
   parameter  int CHANNELS = 4,
   parameter  int DELAY    = 2,
   parameter  int CNT_W    = 16,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int BUS_W    = CHANNELS * WIDTH
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                valid,
   input  logic [BUS_W-1:0]    gold_in,
   input  logic [BUS_W-1:0]    gate_in,
   input  logic [BUS_W-1:0]    care,
   output logic [1:0]          state,
   output logic [CHANNELS-1:0] mismatch,
   output logic                fail,
   output logic [CH_W-1:0]     first_chan,
   output logic [CNT_W-1:0]    first_beat,
   output logic [CNT_W-1:0]    err_count,
   output logic [CNT_W-1:0]    beat_count
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_CHECK  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   localparam state_t ARM_STATE = (DELAY > 0) ? S_WARMUP : S_CHECK;
   localparam int FILL_W = (DELAY > 0) ? $clog2(DELAY + 1) : 1;
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'((DELAY > 0) ? DELAY - 1 : 0);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   function automatic logic [CH_W-1:0] lowest_set(input logic [CHANNELS-1:0] vec);
      logic [CH_W-1:0] idx;
      idx = '0;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
         if (vec[c]) idx = CH_W'(c);
      end
      return idx;
   endfunction

   state_t              r_state;
   state_t              w_state_nxt;
   logic [FILL_W-1:0]   r_fill;
   logic                w_shift;
   logic [BUS_W-1:0]    w_gold_d;
   logic [BUS_W-1:0]    w_diff;
   logic                w_vld_p0;
   logic [CHANNELS-1:0] w_fail_vec_p0;

   logic [CHANNELS-1:0] r_mismatch_p1;
   logic                r_fail_p1;
   logic [CH_W-1:0]     r_first_chan_p1;
   logic [CNT_W-1:0]    r_first_beat_p1;
   logic [CNT_W-1:0]    r_err_p1;
   logic [CNT_W-1:0]    r_beat_p1;

   // start outranks stop and any beat arriving in the same cycle
   always_comb begin
      w_state_nxt = r_state;
      if (start) begin
         w_state_nxt = ARM_STATE;
      end else begin
         case (r_state)
            S_WARMUP: begin
               if (stop)                              w_state_nxt = S_DONE;
               else if (valid && r_fill == FILL_LAST) w_state_nxt = S_CHECK;
            end
            S_CHECK: if (stop) w_state_nxt = S_DONE;
            default: w_state_nxt = r_state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_fill  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (start)                                   r_fill <= '0;
         else if (r_state == S_WARMUP && valid && !stop) r_fill <= r_fill + 1'b1;
      end
   end

   assign w_shift = valid && !start && (r_state == S_WARMUP || r_state == S_CHECK);

   generate
      if (DELAY > 0) begin : g_dl
         logic [BUS_W-1:0] r_gold_dl [DELAY];
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int i = 0; i < DELAY; i++) r_gold_dl[i] <= '0;
            end else if (start) begin
               for (int i = 0; i < DELAY; i++) r_gold_dl[i] <= '0;
            end else if (w_shift) begin
               r_gold_dl[0] <= gold_in;
               for (int i = 1; i < DELAY; i++) r_gold_dl[i] <= r_gold_dl[i-1];
            end
         end
         assign w_gold_d = r_gold_dl[DELAY-1];
      end else begin : g_nodl
         assign w_gold_d = gold_in;
      end
   endgenerate

   // stage 0: masked per-channel compare of the current beat
   assign w_vld_p0 = (r_state == S_CHECK) && valid && !start;
   assign w_diff   = (w_gold_d ^ gate_in) & care;

   always_comb begin
      w_fail_vec_p0 = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_fail_vec_p0[c] = |w_diff[c*WIDTH +: WIDTH];
      end
   end

   // stage 1: registered results, cleared by reset or a new run
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mismatch_p1   <= '0;
         r_fail_p1       <= 1'b0;
         r_first_chan_p1 <= '0;
         r_first_beat_p1 <= '0;
         r_err_p1        <= '0;
         r_beat_p1       <= '0;
      end else if (start) begin
         r_mismatch_p1   <= '0;
         r_fail_p1       <= 1'b0;
         r_first_chan_p1 <= '0;
         r_first_beat_p1 <= '0;
         r_err_p1        <= '0;
         r_beat_p1       <= '0;
      end else if (w_vld_p0) begin
         r_mismatch_p1 <= w_fail_vec_p0;
         r_beat_p1     <= sat_inc(r_beat_p1);
         if (|w_fail_vec_p0) begin
            r_err_p1  <= sat_inc(r_err_p1);
            r_fail_p1 <= 1'b1;
            if (!r_fail_p1) begin
               r_first_chan_p1 <= lowest_set(w_fail_vec_p0);
               r_first_beat_p1 <= r_beat_p1;
            end
         end
      end
   end

   assign state      = r_state;
   assign mismatch   = r_mismatch_p1;
   assign fail       = r_fail_p1;
   assign first_chan = r_first_chan_p1;
   assign first_beat = r_first_beat_p1;
   assign err_count  = r_err_p1;
   assign beat_count = r_beat_p1;

endmodule
